mos_io_port: RTL and testbench
==============================

# mos_io_port

Parametrised on-chip I/O port block for the 6510-class CPU wrapper. It sits between the CPU core and the system data bus and contains the following:
- `NUM_PORTS` pairs of data-direction and output registers, each `WIDTH` bits wide, decoded in a configurable address window.
- The CPU read-data mux, selecting between port registers and the latched external bus.
- Optional emulation of floating-pin charge decay.

It replaces the fixed single 8-bit port at addresses 0/1 and adds multi-port support, configurable reset values and bus-latch gating.

## Interface
- `WIDTH`, 8, bits per port and width of the CPU data path.
- `NUM_PORTS`, 1, number of DDR/data register pairs.
- `BASE_ADDR`, 16'h0000, address of port 0's DDR.
- `DDR_RESET`, 8'h00, DDR reset value, zero-extended or truncated to `WIDTH`.
- `DATA_RESET`, 8'h00, data register reset value.
- `FLOAT_MASK`, 8'h00, bits with no external driver; these are subject to decay.
- `DECAY_CYCLES`, 1024, number of `ce` cycles a floating bit retains charge.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `ce` in 1: CPU phase enable; all state advances only when `ce`=1.
- `addr` in 16: CPU address.
- `we` in 1: CPU write strobe.
- `rdy` in 1: CPU ready; when 0, no register updates occur.
- `wdata` in WIDTH: CPU write data.
- `bus_di` in WIDTH: external bus read data.
- `bus_valid` in 1: bus sample strobe (AEC); latches `bus_di`.
- `rdata` out WIDTH: registered read data to the CPU core.
- `hit` out 1: combinational; `addr` falls in the port window.
- `port_out` out NUM_PORTS*WIDTH: driven values, computed as data & ddr.
- `port_dir` out NUM_PORTS*WIDTH: DDR contents; 1 = output.
- `port_in` in NUM_PORTS*WIDTH: pin input values.

## Operation
- **Address map:** port p DDR is at `BASE_ADDR`+2p; port p data is at `BASE_ADDR`+2p+1.
- **Write** (`ce`&`we`&`rdy`&`hit`): the addressed register loads the full `wdata`. The data register stores all bits unmasked; masking is applied only on `port_out`.
- **Read** (`ce`&!`we`&`rdy`):
  - DDR address: `rdata` <= ddr.
  - Data address: `rdata` <= (data & ddr) | (pin & ~ddr).
  - Non-hit address: `rdata` <= bus latch.
- **Pin value:** pin = `port_in`, except where the fade logic overrides bits in `FLOAT_MASK`.
- **Bus latch:** loads `bus_di` on `ce`&`bus_valid`, independent of `rdy` and `we`.
- **Write cycles:** `rdata` holds its value.
- **Reset values:**
  - ddr = `DDR_RESET`, data = `DATA_RESET` (all ports).
  - `rdata` = 0, bus latch = 0.
  - `port_out` = `DATA_RESET` & `DDR_RESET`, `port_dir` = `DDR_RESET`.
  - Fade counters = 0, held bits = 0.
- **Elaboration:** an error is raised if `BASE_ADDR`+2*`NUM_PORTS`-1 exceeds 16'hFFFF (no address wrap).

## Timing
- Register updates happen on the `clk` edge where `ce`=1. `rdata` is valid from the next edge, giving a read latency of one `ce` cycle.
- `rdy`=0 with `ce`=1: no register, `rdata` or fade-counter load occurs. Fade counters still decrement, because decay is physical.
- Write followed by a read of the same register on the next `ce` returns the new value; there is no bypass within a single cycle.
- Reset asserted mid-decay clears all counters immediately. Reset has priority over any write in the same cycle.

## Configuration
- **With `MOS_IO_PORT_FADE_EN` defined:** each `FLOAT_MASK` bit has a hold bit and a counter of width $clog2(`DECAY_CYCLES`+1).
  - **Output to input:** when a DDR write turns the bit from 1 to 0, hold <= that bit's current data value and counter <= `DECAY_CYCLES`.
  - **While counter > 0 and bit is input:** pin = hold, and the counter decrements each `ce`.
  - **At 0:** pin = 0.
  - **Turning back to output:** the counter clears.
  - **Data writes while the bit is input:** hold is not changed.
- **Without the macro:** all bits read `port_in`. `FLOAT_MASK` and `DECAY_CYCLES` are ignored and no counters are synthesised.

## Structure
- **Package `mos_io_pkg`:**
  - Address offset constants (DDR_OFS=0, DATA_OFS=1).
  - Default reset constants.
  - Function computing counter width from `DECAY_CYCLES`.
- **Sub-module `mos_io_fade_bit`:** one hold bit plus counter, generated per port per masked bit, and present only under the macro.
- **Top level:** the address decode, registers and read mux stay in the top level.

## Test plan
- **Reset:** with `DDR_RESET`=8'h2F, `DATA_RESET`=8'h37, assert reset, then read addr 0 and 1 with `port_in`=8'h00. Expect `rdata`=8'h2F and then 8'h27; `port_out`=8'h27.
- **Two ports:** `NUM_PORTS`=2, `BASE_ADDR`=16'h0010. Write 16'h0012<=8'hF0 and 16'h0013<=8'hAA, with `port_in`[port1]=8'h0F. Reading 16'h0013 gives 8'hAF; reading 16'h0011 is unaffected.
- **Non-hit:** `bus_valid` with `bus_di`=8'h5A, then read 16'hD020. Expect `rdata`=8'h5A; `hit`=0.
- **`rdy`=0:** a write to the DDR is ignored and `rdata` holds its previous value; after `rdy`=1 the write takes effect.
- **Fade** (macro on, `FLOAT_MASK`=8'h80, `DECAY_CYCLES`=4):
  - ddr=8'h80, data=8'h80, then write ddr=8'h00 with `port_in`=0.
  - Bit 7 reads 1 for 4 `ce` cycles, then 0.
  - Switching back to output clears the counter.
- **Fade** (macro off, same stimulus): bit 7 reads 0 immediately.

Source files
------------

// File: rtl/mos_io_port_pkg.sv
// Shared constants and helpers for the mos_io_port I/O port block.
package mos_io_pkg;

    localparam logic DDR_OFS  = 1'b0;
    localparam logic DATA_OFS = 1'b1;

    localparam logic [7:0] DEF_DDR_RESET    = 8'h00;
    localparam logic [7:0] DEF_DATA_RESET   = 8'h00;
    localparam logic [7:0] DEF_FLOAT_MASK   = 8'h00;
    localparam int         DEF_DECAY_CYCLES = 1024;

    // Counter must be able to hold DECAY_CYCLES itself as its load value.
    function automatic int cnt_width(input int decay_cycles);
        if (decay_cycles < 1) begin
            return 1;
        end else begin
            return $clog2(decay_cycles + 1);
        end
    endfunction

endpackage

// File: rtl/mos_io_port_fade_bit.sv
// Charge-decay model for one floating port pin: a held level plus a countdown.
// Only instantiated when MOS_IO_PORT_FADE_EN is defined.
module mos_io_fade_bit
    import mos_io_pkg::*;
#(
    parameter int DECAY_CYCLES = DEF_DECAY_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic dir_load,
    input  logic dir_new,
    input  logic dir_cur,
    input  logic data_cur,
    input  logic pin_ext,
    output logic pin
);

    localparam int            CW       = cnt_width(DECAY_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DECAY_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          hold_r;

    // Capture the driven level on output->input, then let it decay while the pin floats.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            hold_r <= 1'b0;
        end else if (ce) begin
            if (dir_load && dir_cur && !dir_new) begin
                hold_r <= data_cur;
                cnt_r  <= CNT_LOAD;
            end else if (dir_load && dir_new) begin
                cnt_r <= '0;
            end else if ((cnt_r != '0) && !dir_cur) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Floating input reads the held charge until it has leaked away.
    always_comb begin
        pin = pin_ext;
        if (dir_cur) begin
            pin = pin_ext;
        end else if (cnt_r != '0) begin
            pin = hold_r;
        end else begin
            pin = 1'b0;
        end
    end

endmodule

// File: rtl/mos_io_port.sv
// 6510-style on-chip I/O port: NUM_PORTS DDR/data pairs, read mux and bus latch.
// Define MOS_IO_PORT_FADE_EN to model charge decay on FLOAT_MASK pins.
module mos_io_port
    import mos_io_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter int          NUM_PORTS    = 1,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [7:0]  DDR_RESET    = DEF_DDR_RESET,
    parameter logic [7:0]  DATA_RESET   = DEF_DATA_RESET,
    parameter logic [7:0]  FLOAT_MASK   = DEF_FLOAT_MASK,
    parameter int          DECAY_CYCLES = DEF_DECAY_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [15:0]                addr,
    input  logic                       we,
    input  logic                       rdy,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [WIDTH-1:0]           bus_di,
    input  logic                       bus_valid,
    output logic [WIDTH-1:0]           rdata,
    output logic                       hit,
    output logic [NUM_PORTS*WIDTH-1:0] port_out,
    output logic [NUM_PORTS*WIDTH-1:0] port_dir,
    input  logic [NUM_PORTS*WIDTH-1:0] port_in
);

    localparam logic [WIDTH-1:0] DDR_RST  = WIDTH'(DDR_RESET);
    localparam logic [WIDTH-1:0] DATA_RST = WIDTH'(DATA_RESET);
    localparam logic [16:0]      WIN_SIZE = 17'(2 * NUM_PORTS);

    if ((32'(BASE_ADDR) + 32'(2 * NUM_PORTS) - 32'd1) > 32'h0000_FFFF) begin : g_win_err
        $error("mos_io_port: port window wraps past 16'hFFFF");
    end
    if (NUM_PORTS < 1) begin : g_num_err
        $error("mos_io_port: NUM_PORTS must be at least 1");
    end
    if ((DECAY_CYCLES < 1) && (FLOAT_MASK != 8'h00)) begin : g_decay_err
        $error("mos_io_port: DECAY_CYCLES must be positive when FLOAT_MASK is set");
    end

    logic [15:0]      ofs_s;
    logic             wr_s;
    logic             rd_s;
    logic [NUM_PORTS-1:0] port_sel_s;
    logic [NUM_PORTS-1:0] ddr_wr_s;
    logic [WIDTH-1:0] ddr_r    [NUM_PORTS];
    logic [WIDTH-1:0] data_r   [NUM_PORTS];
    logic [WIDTH-1:0] rd_val_s [NUM_PORTS];
    logic [WIDTH-1:0] port_val_s;
    logic [WIDTH-1:0] rd_mux_s;
    logic [WIDTH-1:0] bus_latch_r;

    // Offset is only meaningful when addr >= BASE_ADDR; the compare below guards that.
    assign ofs_s = addr - BASE_ADDR;
    assign hit   = (addr >= BASE_ADDR) && ({1'b0, ofs_s} < WIN_SIZE);
    assign wr_s  = ce & we & rdy & hit;
    assign rd_s  = ce & ~we & rdy;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [WIDTH-1:0] pin_s;

        assign port_sel_s[p] = hit && (ofs_s[15:1] == 15'(p));
        assign ddr_wr_s[p]   = wr_s & port_sel_s[p] & (ofs_s[0] == DDR_OFS);
        assign port_out[p*WIDTH +: WIDTH] = data_r[p] & ddr_r[p];
        assign port_dir[p*WIDTH +: WIDTH] = ddr_r[p];

`ifdef MOS_IO_PORT_FADE_EN
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            if ((b < 8) && FLOAT_MASK[b % 8]) begin : g_fade
                mos_io_fade_bit #(
                    .DECAY_CYCLES(DECAY_CYCLES)
                ) u_fade (
                    .clk      (clk),
                    .reset    (reset),
                    .ce       (ce),
                    .dir_load (ddr_wr_s[p]),
                    .dir_new  (wdata[b]),
                    .dir_cur  (ddr_r[p][b]),
                    .data_cur (data_r[p][b]),
                    .pin_ext  (port_in[p*WIDTH + b]),
                    .pin      (pin_s[b])
                );
            end else begin : g_direct
                assign pin_s[b] = port_in[p*WIDTH + b];
            end
        end
`else
        assign pin_s = port_in[p*WIDTH +: WIDTH];
`endif

        assign rd_val_s[p] = (ofs_s[0] == DATA_OFS) ?
                             ((data_r[p] & ddr_r[p]) | (pin_s & ~ddr_r[p])) : ddr_r[p];
    end

    // Port register file; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                ddr_r[p]  <= DDR_RST;
                data_r[p] <= DATA_RST;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_s && port_sel_s[p] && (ofs_s[0] == DATA_OFS)) begin
                    data_r[p] <= wdata;
                end else if (wr_s && port_sel_s[p]) begin
                    ddr_r[p] <= wdata;
                end else begin
                    data_r[p] <= data_r[p];
                end
            end
        end
    end

    // Read mux: one-hot OR across ports, external bus latch when outside the window.
    always_comb begin
        port_val_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_val_s = port_val_s | (rd_val_s[p] & {WIDTH{port_sel_s[p]}});
        end
        if (hit) begin
            rd_mux_s = port_val_s;
        end else begin
            rd_mux_s = bus_latch_r;
        end
    end

    // Bus latch and registered CPU read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_latch_r <= '0;
            rdata       <= '0;
        end else begin
            if (ce && bus_valid) begin
                bus_latch_r <= bus_di;
            end else begin
                bus_latch_r <= bus_latch_r;
            end
            if (rd_s) begin
                rdata <= rd_mux_s;
            end else begin
                rdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_mos_io_port.sv
// Scoreboard bench for mos_io_port: a 1-port instance with custom resets/fade
// settings and a 2-port instance at 16'h0010 share one CPU-side stimulus stream.
module tb_mos_io_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] addr;
    logic        we;
    logic        rdy;
    logic [7:0]  wdata;
    logic [7:0]  bus_di;
    logic        bus_valid;

    logic [7:0]  rdata_a, port_out_a, port_dir_a, port_in_a;
    logic        hit_a;
    logic [7:0]  rdata_b;
    logic        hit_b;
    logic [15:0] port_out_b, port_dir_b, port_in_b;

    typedef struct packed {
        logic       inst_b;
        logic [7:0] exp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    mos_io_port #(
        .WIDTH(8), .NUM_PORTS(1), .BASE_ADDR(16'h0000),
        .DDR_RESET(8'h2F), .DATA_RESET(8'h37),
        .FLOAT_MASK(8'h80), .DECAY_CYCLES(4)
    ) u_dut_a (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .we(we), .rdy(rdy),
        .wdata(wdata), .bus_di(bus_di), .bus_valid(bus_valid),
        .rdata(rdata_a), .hit(hit_a), .port_out(port_out_a),
        .port_dir(port_dir_a), .port_in(port_in_a)
    );

    mos_io_port #(
        .WIDTH(8), .NUM_PORTS(2), .BASE_ADDR(16'h0010)
    ) u_dut_b (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .we(we), .rdy(rdy),
        .wdata(wdata), .bus_di(bus_di), .bus_valid(bus_valid),
        .rdata(rdata_b), .hit(hit_b), .port_out(port_out_b),
        .port_dir(port_dir_b), .port_in(port_in_b)
    );

    // Monitor: rdata is checked on the falling edge after each flagged cycle.
    always @(posedge clk) begin
        if (chk) begin
            exp_t       e;
            string      nm;
            logic [7:0] act;
            @(negedge clk);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: rdata_a=%h rdata_b=%h, required a queued expectation",
                         rdata_a, rdata_b);
            end else begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = e.inst_b ? rdata_b : rdata_a;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: rdata=%h expected %h", nm, act, e.exp);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One CPU cycle; when do_chk is set, rdata after this edge must equal e.
    task automatic cycle(input logic c, input logic w, input logic r, input logic [15:0] a,
                         input logic [7:0] d, input logic do_chk, input logic inst_b,
                         input logic [7:0] e, input string nm);
        ce = c; we = w; rdy = r; addr = a; wdata = d;
        if (do_chk) begin
            exp_q.push_back('{inst_b: inst_b, exp: e});
            name_q.push_back(nm);
        end
        chk = do_chk;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 8'h00, "");
    endtask

    task automatic rd(input logic [15:0] a, input logic inst_b, input logic [7:0] e, input string nm);
        cycle(1'b1, 1'b0, 1'b1, a, 8'h00, 1'b1, inst_b, e, nm);
    endtask

    task automatic check_hit(input logic [15:0] a, input logic ea, input logic eb, input string nm);
        ce = 1'b0; we = 1'b0; addr = a;
        #1;
        check({nm, "_a"}, {15'd0, hit_a}, {15'd0, ea});
        check({nm, "_b"}, {15'd0, hit_b}, {15'd0, eb});
    endtask

    localparam logic A = 1'b0;
    localparam logic B = 1'b1;

    initial begin
        logic [7:0] fade_exp [5];
`ifdef MOS_IO_PORT_FADE_EN
        fade_exp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
`else
        fade_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        // Reset with a competing DDR write to check reset priority.
        reset = 1'b1; ce = 1'b1; we = 1'b1; rdy = 1'b1; addr = 16'h0000; wdata = 8'hFF;
        bus_di = 8'h00; bus_valid = 1'b0; port_in_a = 8'h00; port_in_b = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; we = 1'b0;
        check("rst_rdata_a", {8'h00, rdata_a}, 16'h0000);
        check("rst_rdata_b", {8'h00, rdata_b}, 16'h0000);
        check("rst_port_out_a", {8'h00, port_out_a}, 16'h0027);
        check("rst_port_dir_a", {8'h00, port_dir_a}, 16'h002F);
        check("rst_port_out_b", port_out_b, 16'h0000);
        rd(16'h0000, A, 8'h2F, "rst_ddr_read");
        rd(16'h0001, A, 8'h27, "rst_data_read");

        // Two-port instance.
        port_in_b = 16'h0F3C;
        wr(16'h0012, 8'hF0);
        wr(16'h0013, 8'hAA);
        rd(16'h0013, B, 8'hAF, "p1_data_read");
        rd(16'h0011, B, 8'h3C, "p0_data_read");
        rd(16'h0012, B, 8'hF0, "p1_ddr_read");
        rd(16'h0010, B, 8'h00, "p0_ddr_read");
        check("p1_port_out_b", port_out_b, 16'hA000);
        check("p1_port_dir_b", port_dir_b, 16'hF000);
        check("port_out_a_untouched", {8'h00, port_out_a}, 16'h0027);
        check_hit(16'h0013, 1'b0, 1'b1, "hit_last");
        check_hit(16'h0014, 1'b0, 1'b0, "hit_past_end");
        check_hit(16'h000F, 1'b0, 1'b0, "hit_below_base");
        check_hit(16'h0001, 1'b1, 1'b0, "hit_a_data");

        // Non-hit read returns the bus latch.
        bus_valid = 1'b1; bus_di = 8'h5A;
        cycle(1'b1, 1'b0, 1'b0, 16'hD020, 8'h00, 1'b0, A, 8'h00, "");
        bus_valid = 1'b0; bus_di = 8'h00;
        rd(16'hD020, A, 8'h5A, "bus_latch_a");
        rd(16'hD020, B, 8'h5A, "bus_latch_b");
        check_hit(16'hD020, 1'b0, 1'b0, "hit_d020");

        // rdy=0 and ce=0 suppress register updates.
        cycle(1'b1, 1'b1, 1'b0, 16'h0000, 8'h55, 1'b1, A, 8'h5A, "rdy0_write_hold");
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, A, 8'h5A, "rdy0_read_hold");
        rd(16'h0000, A, 8'h2F, "rdy0_write_ignored");
        wr(16'h0000, 8'h55);
        rd(16'h0000, A, 8'h55, "rdy1_write_taken");
        cycle(1'b0, 1'b1, 1'b1, 16'h0000, 8'hFF, 1'b0, A, 8'h00, "");
        rd(16'h0000, A, 8'h55, "ce0_write_ignored");
        cycle(1'b1, 1'b1, 1'b1, 16'h0001, 8'h80, 1'b1, A, 8'h55, "write_cycle_hold");

        // Floating bit 7: output high, then switched to input.
        port_in_a = 8'h00;
        wr(16'h0000, 8'h80);
        rd(16'h0001, A, 8'h80, "bit7_output");
        wr(16'h0000, 8'h00);
        for (int k = 0; k < 5; k++) begin
            rd(16'h0001, A, fade_exp[k], $sformatf("fade_read%0d", k));
        end
        wr(16'h0000, 8'h80);
        rd(16'h0001, A, 8'h80, "back_to_output");

        // Reset during decay clears the counter.
        wr(16'h0000, 8'h00);
        rd(16'h0001, A, fade_exp[0], "decay_started");
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, A, 8'h00, "");
        reset = 1'b0;
        rd(16'h0001, A, 8'h27, "reset_mid_decay");

        ce = 1'b0; we = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
